// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Bridges the datapath MAR/MDR to a word RAM and a small memory-mapped
// I/O block: keyboard (KBSR xFE00, KBDR xFE02) and display (DSR xFE04,
// DDR xFE06).
//
// Handshakes:
//   datapath: MIO_EN is a level request held until o_R; o_R pulses for one
//             cycle when the access completes, then the block waits for
//             MIO_EN to drop before it accepts another request.
//   RAM:      o_MEM_EN/o_RW are held from entering MEM_WAIT until i_R is
//             sampled high; RAM read data is taken from i_MEM_OUT on that edge.
//
// Ports:
//   i_Clk, i_Rst_n            clock, asynchronous active-low reset
//   LD_MAR, LD_MDR, BUS       register loads from the bus (IDLE only)
//   MIO_EN, R_W               access request, 1=write / 0=read
//   MDR_VALUE                 MDR contents to the datapath
//   o_MAR, o_MDR, o_MEM_EN,
//   o_RW, i_MEM_OUT, i_R      RAM interface
//   o_R                       access-complete pulse
//   i_KB_DATA, i_KB_STROBE    keyboard character arrival
//   o_DDR, o_DDR_STROBE,
//   i_DISP_READY              display character write / display done
//   o_dbg_state               current FSM state (IDLE=0, MEM_WAIT=1, DONE=2, HOLD=3)
module mem_access_ctrl #(
    parameter int MEM_WORDS = 28800
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic [15:0] BUS,
    input  logic        MIO_EN,
    input  logic        R_W,
    output logic [15:0] MDR_VALUE,
    output logic [15:0] o_MAR,
    output logic [15:0] o_MDR,
    output logic        o_MEM_EN,
    output logic        o_RW,
    input  logic [15:0] i_MEM_OUT,
    input  logic        i_R,
    output logic        o_R,
    input  logic [7:0]  i_KB_DATA,
    input  logic        i_KB_STROBE,
    output logic [7:0]  o_DDR,
    output logic        o_DDR_STROBE,
    input  logic        i_DISP_READY,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_DONE     = 2'd2,
        S_HOLD     = 2'd3
    } state_t;

    localparam logic [31:0] RAM_TOP = 32'(MEM_WORDS);
    localparam logic [15:0] A_KBSR  = 16'hFE00;
    localparam logic [15:0] A_KBDR  = 16'hFE02;
    localparam logic [15:0] A_DSR   = 16'hFE04;
    localparam logic [15:0] A_DDR   = 16'hFE06;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_mar;
    logic [15:0] r_mdr;
    logic        r_mem_en;
    logic        r_rw;
    logic        r_kb_rdy;
    logic [7:0]  r_kb_data;
    logic        r_ds_rdy;
    logic [7:0]  r_ddr;
    logic        r_ddr_strobe;

    logic        w_is_ram;
    logic        w_accept;
    logic        w_ram_done;
    logic        w_io_read;
    logic        w_ddr_write;
    logic        w_kbdr_read;
    logic [15:0] w_io_rd_data;

    // Decode always uses the registered MAR, so the address is the one
    // the datapath loaded before raising MIO_EN.
    assign w_is_ram    = ({16'd0, r_mar} < RAM_TOP);
    assign w_accept    = (r_state == S_IDLE) && MIO_EN;
    assign w_ram_done  = (r_state == S_MEM_WAIT) && i_R;
    assign w_io_read   = w_accept && !w_is_ram && !R_W;
    assign w_ddr_write = w_accept && !w_is_ram && R_W && (r_mar == A_DDR);
    assign w_kbdr_read = w_io_read && (r_mar == A_KBDR);

    // Read data for non-RAM addresses; DDR and unmapped addresses read as 0.
    always_comb begin
        w_io_rd_data = 16'd0;
        case (r_mar)
            A_KBSR:  w_io_rd_data = {r_kb_rdy, 15'd0};
            A_KBDR:  w_io_rd_data = {8'd0, r_kb_data};
            A_DSR:   w_io_rd_data = {r_ds_rdy, 15'd0};
            default: w_io_rd_data = 16'd0;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        o_R    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (MIO_EN) begin
                    w_next = w_is_ram ? S_MEM_WAIT : S_DONE;
                end
            end
            S_MEM_WAIT: begin
                if (i_R) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                o_R    = 1'b1;
                w_next = S_HOLD;
            end
            S_HOLD: begin
                // The request stays high after completion; wait for it to
                // drop so the same request is not issued twice.
                if (!MIO_EN) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_mar        <= 16'd0;
            r_mdr        <= 16'd0;
            r_mem_en     <= 1'b0;
            r_rw         <= 1'b0;
            r_kb_rdy     <= 1'b0;
            r_kb_data    <= 8'd0;
            r_ds_rdy     <= 1'b1;
            r_ddr        <= 8'd0;
            r_ddr_strobe <= 1'b0;
        end else begin
            r_ddr_strobe <= 1'b0;

            if (r_state == S_IDLE) begin
                if (LD_MAR) r_mar <= BUS;
                if (LD_MDR) r_mdr <= BUS;
            end

            if (w_accept) begin
                r_rw <= R_W;
                if (w_is_ram) begin
                    r_mem_en <= 1'b1;
                end
            end

            if (w_io_read) begin
                r_mdr <= w_io_rd_data;
            end

            if (w_ddr_write) begin
                r_ddr        <= r_mdr[7:0];
                r_ddr_strobe <= 1'b1;
            end

            if (w_ram_done) begin
                r_mem_en <= 1'b0;
                if (!r_rw) begin
                    r_mdr <= i_MEM_OUT;
                end
            end

            // Keyboard: an arriving character beats a coincident KBDR read.
            if (w_kbdr_read) r_kb_rdy <= 1'b0;
            if (i_KB_STROBE) begin
                r_kb_rdy  <= 1'b1;
                r_kb_data <= i_KB_DATA;
            end

            // Display: a coincident DDR write beats the ready pulse.
            if (i_DISP_READY) r_ds_rdy <= 1'b1;
            if (w_ddr_write)  r_ds_rdy <= 1'b0;
        end
    end

    assign MDR_VALUE    = r_mdr;
    assign o_MAR        = r_mar;
    assign o_MDR        = r_mdr;
    assign o_MEM_EN     = r_mem_en;
    assign o_RW         = r_rw;
    assign o_DDR        = r_ddr;
    assign o_DDR_STROBE = r_ddr_strobe;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed scenarios followed by random
// accesses, checked against a transaction-level model of the memory map.
module tb_mem_access_ctrl;

    localparam int MEM_WORDS = 28800;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        LD_MAR = 1'b0, LD_MDR = 1'b0, MIO_EN = 1'b0, R_W = 1'b0;
    logic [15:0] BUS = 16'd0;
    logic [15:0] MDR_VALUE, o_MAR, o_MDR;
    logic        o_MEM_EN, o_RW, o_R, o_DDR_STROBE;
    logic [7:0]  o_DDR;
    logic [1:0]  o_dbg_state;
    logic [7:0]  i_KB_DATA = 8'd0;
    logic        i_KB_STROBE = 1'b0, i_DISP_READY = 1'b0;
    logic        ram_r = 1'b0;
    logic [15:0] ram_out = 16'd0;

    mem_access_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .BUS(BUS),
        .MIO_EN(MIO_EN), .R_W(R_W), .MDR_VALUE(MDR_VALUE), .o_MAR(o_MAR), .o_MDR(o_MDR),
        .o_MEM_EN(o_MEM_EN), .o_RW(o_RW), .i_MEM_OUT(ram_out), .i_R(ram_r), .o_R(o_R),
        .i_KB_DATA(i_KB_DATA), .i_KB_STROBE(i_KB_STROBE), .o_DDR(o_DDR),
        .o_DDR_STROBE(o_DDR_STROBE), .i_DISP_READY(i_DISP_READY), .o_dbg_state(o_dbg_state)
    );

    // ---------------- RAM responder ----------------
    // Sees the enable on one edge, answers with i_R (and read data) for one cycle.
    logic [15:0] ram [int];

    function automatic logic [15:0] ram_peek(input logic [15:0] a);
        if (ram.exists(int'(a))) return ram[int'(a)];
        return a ^ 16'hA5C3;
    endfunction

    always @(posedge clk) begin
        ram_r <= o_MEM_EN & ~ram_r;
        if (o_MEM_EN && !ram_r) begin
            if (o_RW) ram[int'(o_MAR)] = o_MDR;
            else      ram_out <= ram_peek(o_MAR);
        end
    end

    // ---------------- monitor ----------------
    int         mem_en_cyc = 0;
    int         r_pulses = 0;
    logic [7:0] obs_q[$];
    always @(negedge clk) begin
        if (o_MEM_EN) mem_en_cyc++;
        if (o_R) r_pulses++;
        if (o_DDR_STROBE) obs_q.push_back(o_DDR);
    end

    // ---------------- scoreboard / model ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    int          obs_rd = 0;
    logic [15:0] m_mdr = 16'd0;
    logic        m_kb_rdy = 1'b0;
    logic [7:0]  m_kb_data = 8'd0;
    logic        m_ds_rdy = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drain_ddr();
        while (obs_rd < obs_q.size()) begin
            if (exp_q.size() == 0) check_eq("ddr_extra_strobe", {24'd0, obs_q[obs_rd]}, 32'hFFFF_FFFF);
            else check_eq("ddr_char", {24'd0, obs_q[obs_rd]}, {24'd0, exp_q.pop_front()});
            obs_rd++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic kb_char(input logic [7:0] d);
        @(negedge clk);
        i_KB_STROBE = 1'b1; i_KB_DATA = d;
        @(negedge clk);
        i_KB_STROBE = 1'b0;
        m_kb_rdy = 1'b1; m_kb_data = d;
    endtask

    task automatic disp_done();
        @(negedge clk);
        i_DISP_READY = 1'b1;
        @(negedge clk);
        i_DISP_READY = 1'b0;
        m_ds_rdy = 1'b1;
    endtask

    // One full access: load MAR (and MDR for writes), request, wait for o_R,
    // hold the request (trying register loads, which must be ignored), release.
    task automatic access(input logic [15:0] addr, input logic [15:0] wdata, input logic rw,
                          input int hold, input bit kb_with, input logic [7:0] kb_d,
                          input bit disp_with);
        int  mem0, r0, cyc;
        bit  is_ram;
        @(negedge clk);
        LD_MAR = 1'b1; BUS = addr;
        @(negedge clk);
        LD_MAR = 1'b0;
        if (rw) begin
            LD_MDR = 1'b1; BUS = wdata;
            @(negedge clk);
            LD_MDR = 1'b0;
            m_mdr = wdata;
        end
        is_ram = (int'(addr) < MEM_WORDS);
        // model: read effects use the state before this access; the keyboard
        // strobe is applied after (set wins), display ready before (clear wins)
        if (is_ram) begin
            if (!rw) m_mdr = ram_peek(addr);
        end else if (!rw) begin
            case (addr)
                16'hFE00: m_mdr = {m_kb_rdy, 15'd0};
                16'hFE02: begin m_mdr = {8'd0, m_kb_data}; m_kb_rdy = 1'b0; end
                16'hFE04: m_mdr = {m_ds_rdy, 15'd0};
                default:  m_mdr = 16'd0;
            endcase
        end else if (addr == 16'hFE06) begin
            exp_q.push_back(m_mdr[7:0]);
        end
        if (kb_with) begin m_kb_rdy = 1'b1; m_kb_data = kb_d; end
        if (disp_with) m_ds_rdy = 1'b1;
        if (rw && addr == 16'hFE06) m_ds_rdy = 1'b0;

        mem0 = mem_en_cyc; r0 = r_pulses;
        MIO_EN = 1'b1; R_W = rw;
        i_KB_STROBE = kb_with; i_KB_DATA = kb_d; i_DISP_READY = disp_with;
        cyc = 0;
        while (1) begin
            @(negedge clk);
            i_KB_STROBE = 1'b0; i_DISP_READY = 1'b0;
            cyc++;
            if (o_R || cyc >= 20) break;
        end
        check_eq("latency", cyc, is_ram ? 3 : 1);
        check_eq("mdr_at_r", {16'd0, MDR_VALUE}, {16'd0, m_mdr});
        check_eq("omdr_at_r", {16'd0, o_MDR}, {16'd0, m_mdr});
        check_eq("mar_at_r", {16'd0, o_MAR}, {16'd0, addr});
        LD_MAR = 1'b1; LD_MDR = 1'b1; BUS = 16'hFFFF;
        repeat (hold) @(negedge clk);
        LD_MAR = 1'b0; LD_MDR = 1'b0; MIO_EN = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("mar_after", {16'd0, o_MAR}, {16'd0, addr});
        check_eq("mdr_after", {16'd0, MDR_VALUE}, {16'd0, m_mdr});
        check_eq("r_pulses", r_pulses - r0, 1);
        check_eq("mem_en_cycles", mem_en_cyc - mem0, is_ram ? 2 : 0);
        check_eq("state_idle", {30'd0, o_dbg_state}, 0);
        drain_ddr();
    endtask

    task automatic rd(input logic [15:0] a);
        access(a, 16'd0, 1'b0, 1, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        access(a, d, 1'b1, 1, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_mdr"}, {16'd0, MDR_VALUE}, 0);
        check_eq({tag, "_mar"}, {16'd0, o_MAR}, 0);
        check_eq({tag, "_mem_en"}, {31'd0, o_MEM_EN}, 0);
        check_eq({tag, "_rw"}, {31'd0, o_RW}, 0);
        check_eq({tag, "_r"}, {31'd0, o_R}, 0);
        check_eq({tag, "_ddr"}, {24'd0, o_DDR}, 0);
        check_eq({tag, "_ddr_strobe"}, {31'd0, o_DDR_STROBE}, 0);
        check_eq({tag, "_state"}, {30'd0, o_dbg_state}, 0);
    endtask

    task automatic reset_mid_access();
        int r0;
        @(negedge clk);
        LD_MAR = 1'b1; BUS = 16'h0010;
        @(negedge clk);
        LD_MAR = 1'b0; MIO_EN = 1'b1; R_W = 1'b0;
        @(negedge clk);
        check_eq("rst_pre_mem_en", {31'd0, o_MEM_EN}, 1);
        r0 = r_pulses;
        #1 rst_n = 1'b0; MIO_EN = 1'b0;
        #1 check_reset_values("rst_mid");
        m_mdr = 16'd0; m_kb_rdy = 1'b0; m_kb_data = 8'd0; m_ds_rdy = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("rst_no_r", r_pulses - r0, 0);
        check_eq("rst_mdr_after", {16'd0, MDR_VALUE}, 0);
        check_eq("rst_mem_en_after", {31'd0, o_MEM_EN}, 0);
        obs_rd = obs_q.size();
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] a;
        int          k;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // RAM write then read back with MDR holding a different value
        wr(16'h0010, 16'hBEEF);
        check_eq("ram_written", {16'd0, ram_peek(16'h0010)}, 32'h0000BEEF);
        wr(16'h0010, 16'h1234);
        wr(16'h0020, 16'hBEEF);
        access(16'h0010, 16'd0, 1'b0, 5, 1'b0, 8'd0, 1'b0);
        check_eq("ram_read_1234", {16'd0, MDR_VALUE}, 32'h00001234);

        // keyboard
        kb_char(8'h41);
        rd(16'hFE00);
        check_eq("kbsr_ready", {16'd0, MDR_VALUE}, 32'h00008000);
        rd(16'hFE02);
        check_eq("kbdr_data", {16'd0, MDR_VALUE}, 32'h00000041);
        rd(16'hFE00);
        check_eq("kbsr_cleared", {16'd0, MDR_VALUE}, 32'h00000000);

        // display
        wr(16'hFE06, 16'h0148);
        rd(16'hFE04);
        check_eq("dsr_busy", {16'd0, MDR_VALUE}, 32'h00000000);
        disp_done();
        rd(16'hFE04);
        check_eq("dsr_ready", {16'd0, MDR_VALUE}, 32'h00008000);

        // unmapped and ignored writes, RAM boundary
        rd(16'h8000);
        wr(16'hFE00, 16'h1234);
        wr(16'hFE02, 16'h5678);
        wr(16'hFE04, 16'h9ABC);
        rd(16'(MEM_WORDS - 1));
        rd(16'(MEM_WORDS));
        rd(16'hFE08);

        // coincident keyboard strobe with KBDR read: old data read, new kept
        kb_char(8'h10);
        access(16'hFE02, 16'd0, 1'b0, 1, 1'b1, 8'h55, 1'b0);
        rd(16'hFE00);
        rd(16'hFE02);
        // coincident display ready with DDR write: stays busy
        access(16'hFE06, 16'h00A7, 1'b1, 2, 1'b0, 8'd0, 1'b1);
        rd(16'hFE04);

        reset_mid_access();
        rd(16'hFE04);

        // random traffic
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 9);
            case (k)
                0, 1:    a = 16'($urandom_range(0, MEM_WORDS - 1));
                2:       a = 16'hFE00;
                3:       a = 16'hFE02;
                4:       a = 16'hFE04;
                5, 6:    a = 16'hFE06;
                default: a = 16'($urandom_range(MEM_WORDS, 16'hFFFF));
            endcase
            if ($urandom_range(0, 3) == 0) kb_char(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) disp_done();
            access(a, 16'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)),
                   $urandom_range(1, 4), 1'($urandom_range(0, 5) == 0),
                   8'($urandom_range(0, 255)), 1'($urandom_range(0, 5) == 0));
        end

        repeat (3) @(negedge clk);
        drain_ddr();
        check_eq("ddr_missing", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 28800, number of implemented RAM words; addresses 0..MEM_WORDS-1 map to RAM.
REQ-002 SHALL have ports: i_Clk  in  1  sole clock, all state on rising edge.
REQ-003 i_Rst_n  in  1  reset, asynchronous, active-low.
REQ-004 LD_MAR  in  1  load MAR from BUS (IDLE only); LD_MDR  in  1  load MDR from BUS (IDLE only).
REQ-005 BUS  in  16  datapath bus value.
REQ-006 MIO_EN  in  1  access request, level, held until o_R; R_W  in  1  1=write, 0=read, sampled at request acceptance.
REQ-007 MDR_VALUE  out  16  current MDR contents, to datapath gate.
REQ-008 o_MAR  out  16  to RAM MAR_OUT; o_MDR  out  16  to RAM MDR_OUT.
REQ-009 o_MEM_EN  out  1  RAM enable; o_RW  out  1  RAM write select.
REQ-010 i_MEM_OUT  in  16  RAM read data; i_R  in  1  RAM done (1 cycle after enable seen).
REQ-011 o_R  out  1  access-complete pulse to datapath.
REQ-012 i_KB_DATA  in  8, i_KB_STROBE  in  1  keyboard character and 1-cycle arrival strobe.
REQ-013 o_DDR  out  8, o_DDR_STROBE  out  1  display character and 1-cycle write strobe; i_DISP_READY  in  1  1-cycle display-done pulse.

Function
REQ-014 FSM states SHALL be IDLE, MEM_WAIT, DONE, HOLD.
REQ-015 IDLE: LD_MAR/LD_MDR load on edge; both high -> both load; MIO_EN=1 accepts request, latches R_W, decodes o_MAR.
REQ-016 Decode: 0..MEM_WORDS-1 RAM; xFE00 KBSR; xFE02 KBDR; xFE04 DSR; xFE06 DDR; anything else UNMAPPED.
REQ-017 RAM request: IDLE->MEM_WAIT; o_MEM_EN=1, o_RW=latched R_W, asserted from the edge entering MEM_WAIT until the edge i_R=1 is sampled.
REQ-018 MEM_WAIT, i_R=1: read -> MDR<=i_MEM_OUT; go DONE, o_MEM_EN=0; i_R=0 -> stay, no timeout.
REQ-019 I/O or UNMAPPED request: IDLE->DONE directly, no RAM enable; 1-cycle latency to o_R.
REQ-020 Reads: KBSR -> MDR={KBRDY,15'b0}; KBDR -> MDR={8'b0,kbdata}, clear KBRDY; DSR -> MDR={DSRDY,15'b0}; DDR/UNMAPPED -> MDR=0.
REQ-021 Writes: DDR -> o_DDR<=MDR[7:0], o_DDR_STROBE=1 one cycle, clear DSRDY; KBSR/KBDR/DSR/UNMAPPED writes ignored, MDR unchanged.
REQ-022 DONE: o_R=1 for exactly one cycle; next HOLD.
REQ-023 HOLD: wait MIO_EN=0 then IDLE; prevents re-issue of held request; LD_MAR/LD_MDR ignored in MEM_WAIT, DONE, HOLD.
REQ-024 i_KB_STROBE: kbdata<=i_KB_DATA, KBRDY<=1 any state; simultaneous with KBDR read completion -> set wins, new data kept.
REQ-025 i_DISP_READY sets DSRDY; coincident with DDR write -> clear wins.
REQ-026 o_MAR, o_MDR, MDR_VALUE SHALL be direct register outputs, stable throughout MEM_WAIT.

Reset
REQ-027 i_Rst_n=0 immediately: state IDLE, MAR=0, MDR=0, o_MEM_EN=0, o_RW=0, o_R=0, KBRDY=0, kbdata=0, DSRDY=1, o_DDR=0, o_DDR_STROBE=0.
REQ-028 Reset mid-access SHALL abort it; no o_R, no MDR update; after release SHALL wait for fresh MIO_EN in IDLE.

Verification
REQ-029 Load MAR=x0010, MDR=xBEEF, MIO_EN=1 R_W=1, RAM model i_R 1 cycle later -> o_MEM_EN high 2 cycles, o_MAR=x0010, o_MDR=xBEEF, one o_R pulse.
REQ-030 MAR=x0010 read, i_MEM_OUT=x1234 with i_R -> MDR_VALUE=x1234 at o_R; MIO_EN held 5 more cycles -> no second o_MEM_EN.
REQ-031 i_KB_STROBE data x41; read xFE00 -> MDR x8000; read xFE02 -> MDR x0041; reread xFE00 -> x0000.
REQ-032 Write xFE06 MDR=x0148 -> o_DDR=x48 strobe 1 cycle, DSR read x0000; i_DISP_READY then DSR read x8000.
REQ-033 Read x8000 (unmapped) -> o_R after 1 cycle, MDR=0, o_MEM_EN never high; write xFE00 -> no state change.
REQ-034 Assert i_Rst_n=0 during MEM_WAIT -> o_MEM_EN drops same cycle, no o_R, MDR=0.
